// File: rtl/mem_responder_pkg.sv
// Shared types for the tagged memory-bus responder: bus commands, tags and
// the completion-pipeline entry.
package mem_responder_pkg;

   localparam int XLEN   = 32;
   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef logic [3:0] MEM_TAG;

   typedef struct packed {
      logic              valid;
      MEM_TAG            tag;
      logic [DATA_W-1:0] data;
   } MEM_RESP_ENTRY;

   // Tags run 1..num_tags; 0 is reserved for "no tag".
   function automatic MEM_TAG tag_next(input MEM_TAG t, input int num_tags);
      return (t == MEM_TAG'(num_tags)) ? MEM_TAG'(1) : t + MEM_TAG'(1);
   endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// LATENCY-deep shift register of completion entries; an empty slot is all
// zeros, so the last stage can drive the bus outputs directly.
module mem_resp_pipe
   import mem_responder_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  MEM_RESP_ENTRY i_entry,
   output MEM_RESP_ENTRY o_entry
);

   MEM_RESP_ENTRY r_stage [LATENCY];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_entry;
         for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_entry = r_stage[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Tagged data-memory responder: backing array, tag allocator and fixed-latency
// completion pipe. Define MEM_BUSY_INJECT_EN to reject every fourth cycle.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4,
   parameter int NUM_TAGS  = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      proc2mem_command,
   input  logic [XLEN-1:0] proc2mem_addr,
   input  logic [63:0]     proc2mem_data,
   output logic [3:0]      mem2proc_response,
   output logic [63:0]     mem2proc_data,
   output logic [3:0]      mem2proc_tag
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [63:0]         r_mem [MEM_WORDS];
   MEM_TAG              r_next_tag;
   logic [NUM_TAGS-1:0] r_inflight;

   logic [AW-1:0]       w_idx;
   logic                w_is_load;
   logic                w_is_store;
   logic                w_busy;
   logic                w_tag_free;
   logic                w_accept;
   logic [NUM_TAGS-1:0] w_next_oh;
   logic [NUM_TAGS-1:0] w_done_oh;
   MEM_RESP_ENTRY       w_issue;
   MEM_RESP_ENTRY       w_done;
   logic                w_unused_addr;

   assign w_idx         = proc2mem_addr[3 +: AW];
   assign w_unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+AW]};
   assign w_is_load     = (proc2mem_command == BUS_LOAD);
   assign w_is_store    = (proc2mem_command == BUS_STORE);

`ifdef MEM_BUSY_INJECT_EN
   logic [1:0] r_busy_cnt;

   always_ff @(posedge clock) begin
      if (reset) r_busy_cnt <= '0;
      else       r_busy_cnt <= r_busy_cnt + 2'd1;
   end

   assign w_busy = (r_busy_cnt == 2'd3);
`else
   assign w_busy = 1'b0;
`endif

   // A tag retiring this cycle counts as free so it can be reissued at once.
   assign w_next_oh  = NUM_TAGS'(1) << (r_next_tag - MEM_TAG'(1));
   assign w_done_oh  = w_done.valid ? (NUM_TAGS'(1) << (w_done.tag - MEM_TAG'(1))) : '0;
   assign w_tag_free = ~|(r_inflight & w_next_oh & ~w_done_oh);
   assign w_accept   = !reset && (w_is_load || w_is_store) && w_tag_free && !w_busy;

   always_comb begin
      w_issue = '0;
      if (w_accept) begin
         w_issue.valid = 1'b1;
         w_issue.tag   = r_next_tag;
         if (w_is_load) w_issue.data = r_mem[w_idx];
      end
   end

   // Array is deliberately outside reset so stores survive a pipeline flush.
   always_ff @(posedge clock) begin
      if (w_accept && w_is_store) r_mem[w_idx] <= proc2mem_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_next_tag <= MEM_TAG'(1);
         r_inflight <= '0;
      end else begin
         r_inflight <= (r_inflight & ~w_done_oh) | (w_accept ? w_next_oh : '0);
         if (w_accept) r_next_tag <= tag_next(r_next_tag, NUM_TAGS);
      end
   end

   mem_resp_pipe #(
      .LATENCY (LATENCY)
   ) u_pipe (
      .i_clock (clock),
      .i_reset (reset),
      .i_entry (w_issue),
      .o_entry (w_done)
   );

   assign mem2proc_response = w_accept ? r_next_tag : '0;
   assign mem2proc_tag      = w_done.tag;
   assign mem2proc_data     = w_done.data;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responder configurations driven in lockstep and
// compared every cycle against a cycle-scheduled reference model.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd   = 2'd0;
   logic [31:0] addr  = '0;
   logic [63:0] wdata = '0;

   logic [3:0]  resp_a, tag_a, resp_b, tag_b;
   logic [63:0] data_a, data_b;

   always #5 clock = ~clock;

   mem_responder #(.MEM_WORDS(1024), .LATENCY(4), .NUM_TAGS(15)) dut_a (
      .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp_a), .mem2proc_data(data_a),
      .mem2proc_tag(tag_a));

   mem_responder #(.MEM_WORDS(16), .LATENCY(15), .NUM_TAGS(3)) dut_b (
      .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
      .proc2mem_data(wdata), .mem2proc_response(resp_b), .mem2proc_data(data_b),
      .mem2proc_tag(tag_b));

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model: completions are scheduled by absolute cycle number.
   int          m_lat [2] = '{4, 15};
   int          m_nt  [2] = '{15, 3};
   int          m_mw  [2] = '{1024, 16};
   int          m_next [2];
   bit          m_infl [2][16];
   int          due_tag  [2][32];
   logic [63:0] due_data [2][32];
   bit          due_dk   [2][32];
   logic [63:0] m_mem   [2][1024];
   bit          m_known [2][1024];
   int          m_cnt;
   int          cyc = 0;

   logic [3:0]  o_resp [2];
   logic [3:0]  o_tag  [2];
   logic [63:0] o_data [2];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_next[k] = 1;
         for (int t = 0; t < 16; t++) m_infl[k][t] = 1'b0;
         for (int s = 0; s < 32; s++) begin
            due_tag[k][s] = 0; due_data[k][s] = '0; due_dk[k][s] = 1'b1;
         end
      end
      m_cnt = 0;
   endtask

   // One bus cycle: drive, check at negedge, advance model at posedge.
   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                       input logic r);
      bit acc [2];
      bit busy;
      int slot, idx;
      reset = r; cmd = c; addr = a; wdata = d;
      @(negedge clock);
      o_resp = '{resp_a, resp_b};
      o_tag  = '{tag_a, tag_b};
      o_data = '{data_a, data_b};
      slot = cyc % 32;
`ifdef MEM_BUSY_INJECT_EN
      busy = (m_cnt == 3);
`else
      busy = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         acc[k] = !r && (c == 2'd1 || c == 2'd2) && !busy &&
                  !(m_infl[k][m_next[k]] && due_tag[k][slot] != m_next[k]);
         chk($sformatf("resp%0d", k), 64'(o_resp[k]), acc[k] ? 64'(m_next[k]) : 64'd0);
         chk($sformatf("tag%0d", k), 64'(o_tag[k]), 64'(due_tag[k][slot]));
         if (due_dk[k][slot]) chk($sformatf("data%0d", k), o_data[k], due_data[k][slot]);
      end
      @(posedge clock);
      if (r) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (due_tag[k][slot] != 0) m_infl[k][due_tag[k][slot]] = 1'b0;
            due_tag[k][slot] = 0; due_data[k][slot] = '0; due_dk[k][slot] = 1'b1;
            if (acc[k]) begin
               idx = int'(a >> 3) % m_mw[k];
               due_tag[k][(cyc + m_lat[k]) % 32] = m_next[k];
               if (c == 2'd1) begin
                  due_data[k][(cyc + m_lat[k]) % 32] = m_mem[k][idx];
                  due_dk[k][(cyc + m_lat[k]) % 32]   = m_known[k][idx];
               end else begin
                  due_data[k][(cyc + m_lat[k]) % 32] = '0;
                  due_dk[k][(cyc + m_lat[k]) % 32]   = 1'b1;
                  m_mem[k][idx] = d; m_known[k][idx] = 1'b1;
               end
               m_infl[k][m_next[k]] = 1'b1;
               m_next[k] = (m_next[k] == m_nt[k]) ? 1 : m_next[k] + 1;
            end
         end
         m_cnt = (m_cnt + 1) % 4;
      end
      cyc++;
      #1;
   endtask

   initial begin
      int n;
      int t;
      model_reset();
      @(posedge clock); #1;

      // Reset/idle, then a LOAD while still in reset.
      for (int i = 0; i < 5; i++) begin
         step(2'd0, '0, '0, 1'b1);
         chk("rst_resp", 64'(o_resp[0]), 64'd0);
         chk("rst_tag", 64'(o_tag[0]), 64'd0);
         chk("rst_data", o_data[0], 64'd0);
      end
      step(2'd1, 32'h10, '0, 1'b1);
      chk("rst_load_resp", 64'(o_resp[0]), 64'd0);
      for (int i = 0; i < 5; i++) step(2'd0, '0, '0, 1'b0);

`ifndef MEM_BUSY_INJECT_EN
      // Store then load-after-store to the same word.
      step(2'd0, '0, '0, 1'b1);
      step(2'd2, 32'h10, 64'hDEAD_BEEF_0000_0001, 1'b0);
      chk("st_resp", 64'(o_resp[0]), 64'd1);
      step(2'd1, 32'h10, '0, 1'b0);
      chk("ld_resp", 64'(o_resp[0]), 64'd2);
      step(2'd0, '0, '0, 1'b0);
      step(2'd0, '0, '0, 1'b0);
      step(2'd0, '0, '0, 1'b0);
      chk("st_done_tag", 64'(o_tag[0]), 64'd1);
      chk("st_done_data", o_data[0], 64'd0);
      step(2'd0, '0, '0, 1'b0);
      chk("ld_done_tag", 64'(o_tag[0]), 64'd2);
      chk("ld_done_data", o_data[0], 64'hDEAD_BEEF_0000_0001);

      // 16 back-to-back loads: tags wrap 15 -> 1, completions contiguous.
      step(2'd0, '0, '0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(i < 16 ? 2'd1 : 2'd0, 32'(i * 8), '0, 1'b0);
         if (i < 16) chk("b2b_resp", 64'(o_resp[0]), 64'((i % 15) + 1));
         if (i >= 4) chk("b2b_done", 64'(o_tag[0]), 64'(((i - 4) % 15) + 1));
      end

      // Tag exhaustion on the LATENCY=15 / 3-tag build.
      step(2'd0, '0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(2'd1, 32'h40, '0, 1'b0);
         chk("exh_resp", 64'(o_resp[1]), 64'(i + 1));
      end
      n = 3;
      forever begin
         step(2'd1, 32'h40, '0, 1'b0);
         if (o_resp[1] != 4'd0 || n >= 40) break;
         n++;
      end
      chk("exh_cycle", 64'(n), 64'd15);
      chk("exh_reissue", 64'(o_resp[1]), 64'd1);
`endif

      // Reset with loads in flight drops them.
      step(2'd0, '0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step(2'd1, 32'(i * 8), '0, 1'b0);
      step(2'd0, '0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(2'd0, '0, '0, 1'b0);
         chk("drop_tag_a", 64'(o_tag[0]), 64'd0);
         chk("drop_tag_b", 64'(o_tag[1]), 64'd0);
      end
`ifndef MEM_BUSY_INJECT_EN
      step(2'd1, 32'h0, '0, 1'b0);
      chk("post_rst_tag", 64'(o_resp[0]), 64'd1);
`endif

`ifdef MEM_BUSY_INJECT_EN
      // Held LOAD: every fourth cycle rejected without consuming a tag.
      step(2'd0, '0, '0, 1'b1);
      t = 1;
      for (int i = 0; i < 12; i++) begin
         step(2'd1, 32'(i * 8), '0, 1'b0);
         if (i % 4 == 3) begin
            chk("busy_rej", 64'(o_resp[0]), 64'd0);
         end else begin
            chk("busy_acc", 64'(o_resp[0]), 64'(t));
            t = (t == 15) ? 1 : t + 1;
         end
      end
`endif

      // Randomized traffic over a small address window to force word reuse.
      for (int i = 0; i < 600; i++) begin
         step(2'($urandom_range(0, 3)),
              {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0,
               7'($urandom_range(0, 127)), 3'($urandom)},
              {$urandom, $urandom},
              $urandom_range(0, 59) == 0);
      end
      for (int i = 0; i < 20; i++) step(2'd0, '0, '0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
